// File: rtl/vec_op_sequencer.sv
// vec_op_sequencer
//   Takes one decoded vector op from ID and splits its element vector into
//   LANES-wide chunks. It issues one chunk per cycle to the multiplier/adder
//   datapath and follows each issued chunk through a fixed-latency pipe, so
//   that writeback strobes and the completion pulse come out on the right
//   cycle.
// Ports
//   clk, rst                      clock, asynchronous active-high reset
//   req_valid/req_ready           op handshake with ID (ready only in IDLE)
//   req_op/req_len/req_dst        op (00 VADD, 01 VMUL, 10 VDOT, 11 NOP),
//                                 element count, destination register
//   dp_stall                      back-pressure; holds back further issues
//   dp_issue/dp_op/dp_chunk       chunk issue strobe, op, chunk index
//   dp_lane_mask                  active lanes of the issued chunk
//   dp_acc_clr/dp_reduce          VDOT accumulator clear / reduction routing
//   wb_valid/wb_dst/wb_chunk      result writeback
//   done/err                      completion / illegal-length pulses
//   busy                          sequencer not idle
module vec_op_sequencer #(
  parameter int LANES   = 8,
  parameter int MAX_LEN = 64,
  parameter int ALU_LAT = 3,
  parameter int DST_W   = 4,
  localparam int LEN_W  = $clog2(MAX_LEN + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [LEN_W-1:0] req_len,
  input  logic [DST_W-1:0] req_dst,
  input  logic             dp_stall,
  output logic             dp_issue,
  output logic [1:0]       dp_op,
  output logic [LEN_W-1:0] dp_chunk,
  output logic [LANES-1:0] dp_lane_mask,
  output logic             dp_acc_clr,
  output logic             dp_reduce,
  output logic             wb_valid,
  output logic [DST_W-1:0] wb_dst,
  output logic [LEN_W-1:0] wb_chunk,
  output logic             done,
  output logic             err,
  output logic             busy
);

  localparam int LOG_L = $clog2(LANES);
  localparam logic [1:0] OP_VDOT = 2'b10;
  localparam logic [1:0] OP_NOP  = 2'b11;
  localparam logic [LEN_W-1:0] MAX_LEN_V = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0] REM_MASK  = LEN_W'(LANES - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t           state;
  logic [1:0]       op_reg;
  logic [DST_W-1:0] dst_reg;
  logic [LEN_W-1:0] nc_reg;     // number of chunks of the current op
  logic [LEN_W-1:0] rem_reg;    // len mod LANES, selects the last-chunk mask
  logic [LEN_W-1:0] chunk_reg;  // index of the next chunk to issue

  logic             accept, legal, start, issue_now, iss_last, pipe_empty;
  logic [1:0]       iss_op;
  logic [LEN_W-1:0] iss_idx, iss_nc, iss_rem, req_nc;
  logic [LEN_W:0]   len_round;
  logic [LANES-1:0] iss_mask;

  // Latency pipe: one slot per cycle of ALU latency. A slot is valid only
  // when its chunk produces a writeback (every chunk for VADD/VMUL, the last
  // chunk only for VDOT).
  logic [ALU_LAT-1:0] pipe_valid, pipe_last, valid_in, last_in;
  logic [LEN_W-1:0]   pipe_chunk [ALU_LAT];
  logic [LEN_W-1:0]   chunk_in   [ALU_LAT];

  assign len_round  = {1'b0, req_len} + (LEN_W + 1)'(LANES - 1);
  assign req_nc     = LEN_W'(len_round >> LOG_L);
  assign pipe_empty = ~|pipe_valid;

  // The chunk issued this cycle comes straight from the request when the op
  // is accepted (so chunk 0 leaves on the accept edge), otherwise from the
  // latched op state.
  always_comb begin
    accept    = (state == IDLE) && req_valid;
    legal     = (req_len != '0) && (req_len <= MAX_LEN_V);
    start     = accept && (req_op != OP_NOP) && legal;
    iss_op    = (state == IDLE) ? req_op : op_reg;
    iss_idx   = (state == IDLE) ? '0 : chunk_reg;
    iss_nc    = (state == IDLE) ? req_nc : nc_reg;
    iss_rem   = (state == IDLE) ? (req_len & REM_MASK) : rem_reg;
    issue_now = start || ((state == ISSUE) && !dp_stall);
    iss_last  = (iss_idx == iss_nc - LEN_W'(1));
    iss_mask  = '1;
    if (iss_last && (iss_rem != '0))
      iss_mask = (LANES'(1) << iss_rem) - LANES'(1);
  end

  assign valid_in[0] = issue_now && ((iss_op != OP_VDOT) || iss_last);
  assign last_in[0]  = issue_now && iss_last;
  assign chunk_in[0] = (iss_op == OP_VDOT) ? '0 : iss_idx;

  generate
    for (genvar gi = 1; gi < ALU_LAT; gi++) begin : g_pipe
      assign valid_in[gi] = pipe_valid[gi-1];
      assign last_in[gi]  = pipe_last[gi-1];
      assign chunk_in[gi] = pipe_chunk[gi-1];
    end
  endgenerate

  // The pipe shifts every cycle regardless of stall; a stalled cycle simply
  // inserts an empty slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe_valid <= '0;
      pipe_last  <= '0;
      pipe_chunk <= '{default: '0};
    end else begin
      pipe_valid <= valid_in;
      pipe_last  <= last_in;
      pipe_chunk <= chunk_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      op_reg       <= '0;
      dst_reg      <= '0;
      nc_reg       <= '0;
      rem_reg      <= '0;
      chunk_reg    <= '0;
      req_ready    <= 1'b1;
      busy         <= 1'b0;
      dp_issue     <= 1'b0;
      dp_op        <= '0;
      dp_chunk     <= '0;
      dp_lane_mask <= '0;
      dp_acc_clr   <= 1'b0;
      dp_reduce    <= 1'b0;
      wb_valid     <= 1'b0;
      wb_dst       <= '0;
      wb_chunk     <= '0;
      done         <= 1'b0;
      err          <= 1'b0;
    end else begin
      dp_issue   <= issue_now;
      dp_acc_clr <= issue_now && (iss_op == OP_VDOT) && (iss_idx == '0);
      dp_reduce  <= issue_now && (iss_op == OP_VDOT);
      // Under stall the chunk index and mask of the last issue are held.
      if (issue_now) begin
        dp_op        <= iss_op;
        dp_chunk     <= iss_idx;
        dp_lane_mask <= iss_mask;
        chunk_reg    <= iss_idx + LEN_W'(1);
      end
      wb_valid <= pipe_valid[ALU_LAT-1];
      if (pipe_valid[ALU_LAT-1]) begin
        wb_chunk <= pipe_chunk[ALU_LAT-1];
        wb_dst   <= dst_reg;
      end
      done <= (pipe_valid[ALU_LAT-1] && pipe_last[ALU_LAT-1]) ||
              (accept && (req_op == OP_NOP));
      err  <= accept && (req_op != OP_NOP) && !legal;

      case (state)
        IDLE: begin
          if (start) begin
            op_reg    <= req_op;
            dst_reg   <= req_dst;
            nc_reg    <= req_nc;
            rem_reg   <= iss_rem;
            req_ready <= 1'b0;
            busy      <= 1'b1;
            state     <= iss_last ? DRAIN : ISSUE;
          end
        end
        ISSUE: begin
          if (issue_now && iss_last)
            state <= DRAIN;
        end
        DRAIN: begin
          // The final writeback and done leave the pipe on the edge before
          // it reads empty, so ready rises the cycle after done.
          if (pipe_empty) begin
            state     <= IDLE;
            req_ready <= 1'b1;
            busy      <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vec_op_sequencer.sv
// Testbench for vec_op_sequencer: table of directed ops, hand-written reset
// and back-to-back sequences, and random ops checked against a chunk/queue
// reference model.
module tb_vec_op_sequencer;

  localparam int LANES   = 8;
  localparam int MAX_LEN = 64;
  localparam int ALU_LAT = 3;
  localparam int DST_W   = 4;
  localparam int LEN_W   = 7;
  localparam logic [1:0] VADD = 2'b00, VMUL = 2'b01, VDOT = 2'b10, NOP = 2'b11;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             req_valid = 1'b0;
  logic             req_ready;
  logic [1:0]       req_op = '0;
  logic [LEN_W-1:0] req_len = '0;
  logic [DST_W-1:0] req_dst = '0;
  logic             dp_stall = 1'b0;
  logic             dp_issue;
  logic [1:0]       dp_op;
  logic [LEN_W-1:0] dp_chunk;
  logic [LANES-1:0] dp_lane_mask;
  logic             dp_acc_clr, dp_reduce, wb_valid, done, err, busy;
  logic [DST_W-1:0] wb_dst;
  logic [LEN_W-1:0] wb_chunk;

  vec_op_sequencer #(.LANES(LANES), .MAX_LEN(MAX_LEN), .ALU_LAT(ALU_LAT), .DST_W(DST_W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_len(req_len), .req_dst(req_dst),
    .dp_stall(dp_stall), .dp_issue(dp_issue), .dp_op(dp_op), .dp_chunk(dp_chunk),
    .dp_lane_mask(dp_lane_mask), .dp_acc_clr(dp_acc_clr), .dp_reduce(dp_reduce),
    .wb_valid(wb_valid), .wb_dst(wb_dst), .wb_chunk(wb_chunk),
    .done(done), .err(err), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Issues one op and follows it cycle by cycle. r counts sampling points
  // (negedges) after the accept edge: chunk 0 is visible at r=0, a stall
  // driven at r blocks the issue at r+1, each writeback appears ALU_LAT
  // samples after its issue. stall_mode < 0 means random stall, otherwise
  // bit r of stall_mode is the stall driven at sample r.
  task automatic run_op(input logic [1:0] op, input int len, input logic [3:0] dst,
                        input int stall_mode, output int n_iss, output int n_wb,
                        output logic [7:0] last_mask, output bit saw_err, output bit saw_done);
    int nc, rem, next_chunk, done_r, waitc;
    bit legal, nop, exp_iss, exp_wb, exp_ready, stall_prev, finished;
    logic [7:0] exp_mask;
    int wb_t[$];
    int wb_c[$];
    legal = (len >= 1) && (len <= MAX_LEN);
    nop   = (op == NOP);
    nc    = (len + LANES - 1) / LANES;
    rem   = len % LANES;
    n_iss = 0; n_wb = 0; last_mask = '0; saw_err = 0; saw_done = 0;
    next_chunk = 0; done_r = -1; stall_prev = 0; finished = 0; waitc = 0;
    while (req_ready !== 1'b1 && waitc < 100) begin
      @(negedge clk);
      waitc++;
    end
    chk("ready_before_req", req_ready, 1);
    req_valid = 1'b1; req_op = op; req_len = LEN_W'(len); req_dst = dst; dp_stall = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    for (int r = 0; r < 200 && !finished; r++) begin
      exp_iss = legal && !nop && (next_chunk < nc) && (r == 0 || !stall_prev);
      chk("dp_issue", dp_issue, exp_iss);
      if (dp_issue === 1'b1) begin
        n_iss++;
        last_mask = dp_lane_mask;
      end
      if (exp_iss) begin
        exp_mask = (next_chunk == nc - 1 && rem != 0) ? 8'((1 << rem) - 1) : 8'hFF;
        chk("dp_chunk", dp_chunk, next_chunk);
        chk("dp_lane_mask", dp_lane_mask, exp_mask);
        chk("dp_op", dp_op, op);
        chk("dp_acc_clr", dp_acc_clr, (op == VDOT) && (next_chunk == 0));
        chk("dp_reduce", dp_reduce, op == VDOT);
        if (op != VDOT || next_chunk == nc - 1) begin
          wb_t.push_back(r + ALU_LAT);
          wb_c.push_back((op == VDOT) ? 0 : next_chunk);
        end
        next_chunk++;
      end
      exp_wb = (wb_t.size() > 0) && (wb_t[0] == r);
      chk("wb_valid", wb_valid, exp_wb);
      if (wb_valid === 1'b1) n_wb++;
      if (exp_wb) begin
        chk("wb_chunk", wb_chunk, wb_c[0]);
        chk("wb_dst", wb_dst, dst);
        void'(wb_t.pop_front());
        void'(wb_c.pop_front());
        if (wb_t.size() == 0 && next_chunk == nc) done_r = r;
      end
      chk("done", done, (nop && r == 0) || (done_r == r));
      if (done === 1'b1) saw_done = 1;
      chk("err", err, !nop && !legal && r == 0);
      if (err === 1'b1) saw_err = 1;
      exp_ready = (legal && !nop) ? (done_r >= 0 && r > done_r) : 1'b1;
      chk("req_ready", req_ready, exp_ready);
      chk("busy", busy, !exp_ready);
      if (exp_ready && r >= 1) finished = 1;
      stall_prev = (stall_mode < 0) ? ($urandom_range(0, 2) == 0) : bit'((stall_mode >> r) & 1);
      dp_stall = stall_prev;
      @(negedge clk);
    end
    dp_stall = 1'b0;
    chk("op_finished", finished, 1);
    $display("op=%0d len=%0d dst=%0d issues=%0d wbs=%0d err=%0d done=%0d", op, len, dst, n_iss, n_wb, saw_err, saw_done);
  endtask

  typedef struct {
    logic [1:0] op;
    int         len;
    logic [3:0] dst;
    int         stall;
    int         exp_iss;
    logic [7:0] exp_mask;
    bit         exp_err;
    bit         exp_done;
    int         exp_wb;
  } vec_t;

  vec_t vecs [11];

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_iss, n_wb, cnt_wb, cnt_done, cnt_iss;
    logic [7:0] lm;
    bit se, sd;
    logic [1:0] rop;

    vecs = '{
      '{VMUL, 20, 4'h1, 0,      3, 8'h0F, 1'b0, 1'b1, 3},
      '{VDOT,  8, 4'h2, 0,      1, 8'hFF, 1'b0, 1'b1, 1},
      '{VADD, 24, 4'h3, 'b11,   3, 8'hFF, 1'b0, 1'b1, 3},
      '{VMUL,  0, 4'h4, 0,      0, 8'h00, 1'b1, 1'b0, 0},
      '{VADD, 65, 4'h5, 0,      0, 8'h00, 1'b1, 1'b0, 0},
      '{NOP,   5, 4'h6, 0,      0, 8'h00, 1'b0, 1'b1, 0},
      '{VDOT, 64, 4'h7, 'b101,  8, 8'hFF, 1'b0, 1'b1, 1},
      '{VADD,  1, 4'h8, 0,      1, 8'h01, 1'b0, 1'b1, 1},
      '{VMUL, 63, 4'h9, 'b1010, 8, 8'h7F, 1'b0, 1'b1, 8},
      '{VDOT, 17, 4'hA, 0,      3, 8'h01, 1'b0, 1'b1, 1},
      '{NOP,   0, 4'hB, 0,      0, 8'h00, 1'b0, 1'b1, 0}
    };

    // Reset state
    repeat (2) @(negedge clk);
    chk("reset_req_ready", req_ready, 1);
    chk("reset_busy", busy, 0);
    chk("reset_dp_issue", dp_issue, 0);
    chk("reset_wb_valid", wb_valid, 0);
    chk("reset_done", done, 0);
    chk("reset_err", err, 0);
    chk("reset_lane_mask", dp_lane_mask, 0);
    rst = 1'b0;
    @(negedge clk);

    // Directed table
    foreach (vecs[i]) begin
      run_op(vecs[i].op, vecs[i].len, vecs[i].dst, vecs[i].stall, n_iss, n_wb, lm, se, sd);
      chk("tbl_issues", n_iss, vecs[i].exp_iss);
      chk("tbl_wbs", n_wb, vecs[i].exp_wb);
      if (vecs[i].exp_iss > 0) chk("tbl_last_mask", lm, vecs[i].exp_mask);
      chk("tbl_err", se, vecs[i].exp_err);
      chk("tbl_done", sd, vecs[i].exp_done);
    end

    // Reset during DRAIN of VMUL len=16: nothing in flight may surface.
    req_valid = 1'b1; req_op = VMUL; req_len = 7'd16; req_dst = 4'h5;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("pre_rst_busy", busy, 1);
    rst = 1'b1;
    #1;
    chk("rst_req_ready", req_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_dp_issue", dp_issue, 0);
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_done", done, 0);
    chk("rst_dp_chunk", dp_chunk, 0);
    chk("rst_lane_mask", dp_lane_mask, 0);
    @(negedge clk);
    rst = 1'b0;
    cnt_wb = 0; cnt_done = 0; cnt_iss = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (wb_valid !== 1'b0) cnt_wb++;
      if (done !== 1'b0) cnt_done++;
      if (dp_issue !== 1'b0) cnt_iss++;
    end
    chk("post_rst_wb", cnt_wb, 0);
    chk("post_rst_done", cnt_done, 0);
    chk("post_rst_issue", cnt_iss, 0);
    chk("post_rst_ready", req_ready, 1);
    $display("reset during drain sequence: wb=%0d done=%0d issue=%0d", cnt_wb, cnt_done, cnt_iss);

    // Back-to-back: VMUL len=8 then VDOT len=9 held valid.
    req_valid = 1'b1; req_op = VMUL; req_len = 7'd8; req_dst = 4'h3;
    @(negedge clk);
    req_op = VDOT; req_len = 7'd9; req_dst = 4'h7;
    for (int r = 0; r < 12; r++) begin
      chk("b2b_issue", dp_issue, r == 0 || r == 5 || r == 6);
      chk("b2b_done", done, r == 3 || r == 9);
      chk("b2b_wb", wb_valid, r == 3 || r == 9);
      chk("b2b_ready", req_ready, r == 4 || r >= 10);
      if (r == 5) begin
        chk("b2b_mask0", dp_lane_mask, 8'hFF);
        chk("b2b_op", dp_op, VDOT);
        chk("b2b_acc_clr0", dp_acc_clr, 1);
        chk("b2b_reduce0", dp_reduce, 1);
        req_valid = 1'b0;
      end
      if (r == 6) begin
        chk("b2b_mask1", dp_lane_mask, 8'h01);
        chk("b2b_chunk1", dp_chunk, 1);
        chk("b2b_acc_clr1", dp_acc_clr, 0);
        chk("b2b_reduce1", dp_reduce, 1);
      end
      if (r == 9) begin
        chk("b2b_wb_chunk", wb_chunk, 0);
        chk("b2b_wb_dst", wb_dst, 7);
      end
      @(negedge clk);
    end
    $display("back-to-back VMUL len=8 / VDOT len=9 sequence complete");

    // Random ops with random stall against the reference model.
    for (int k = 0; k < 30; k++) begin
      rop = 2'($urandom_range(0, 3));
      run_op(rop, int'($urandom_range(0, 70)), 4'($urandom_range(0, 15)), -1, n_iss, n_wb, lm, se, sd);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
